// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and frame check helper for the PS/2 keyboard decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL    = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_t;

  // Frame layout after start bit: [7:0] data, [8] parity, [9] stop; odd parity over data+parity.
  function automatic logic ps2_frame_ok(input logic [9:0] frame);
    return (^frame[8:0]) & frame[9];
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines and debounces the clock line; emits a one-cycle
// pulse on every filtered falling edge of the PS/2 clock.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_f,
  output logic dat_s,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // cnt_q counts consecutive synced samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    fall_d = 1'b0;
    if (clk_s2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILT_LEN - 1)) begin
      filt_d = ~filt_q;
      cnt_d  = '0;
      fall_d = filt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat_i;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
    end
  end

  assign clk_f = filt_q;
  assign dat_s = dat_s2_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host frame receiver producing the toggle-strobe key event word
// {toggle, pressed, extended, scancode} with E0/F0 prefix tracking.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 50000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int               TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TMAX = TO_W'(TIMEOUT);

  logic clk_f_unused;
  logic dat_s;
  logic fall;

  ps2_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk_sys   (clk_sys),
    .RESET     (RESET),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .clk_f     (clk_f_unused),
    .dat_s     (dat_s),
    .fall      (fall)
  );

  ps2_state_t      state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic            ext_q, ext_d;
  logic            rel_q, rel_d;
  logic [10:0]     key_q, key_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      rx_byte;

  assign rx_byte = shift_q[7:0];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    key_d     = key_q;
    err_d     = 1'b0;
    to_d      = to_q;
    case (state_q)
      IDLE: begin
        if (fall && !dat_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          to_d      = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          // Right shift so the first data bit ends up in shift_q[0].
          shift_d   = {dat_s, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          to_d      = '0;
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 2)) begin
            state_d = CHECK;
          end
        end else if (to_q != TMAX) begin
          to_d = to_q + 1'b1;
          if (to_q == TMAX - 1'b1) begin
            err_d     = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = '0;
            ext_d     = 1'b0;
            rel_d     = 1'b0;
          end
        end
      end
      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        if (ps2_frame_ok(shift_q)) begin
          if (rx_byte == PS2_PFX_EXT) begin
            ext_d = 1'b1;
          end else if (rx_byte == PS2_PFX_REL) begin
            rel_d = 1'b1;
          end else begin
            key_d = {~key_q[10], ~rel_q, ext_q, rx_byte};
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end else begin
          err_d = 1'b1;
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      key_q     <= '0;
      err_q     <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      key_q     <= key_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives the raw PS/2 keyboard serial lines, deserialises device-to-host frames and tracks the E0/F0 prefix bytes.
- Produces the 11-bit toggle-strobe key event word that the core's keyboard handling consumes: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- Sits between the PS/2 pins (or a passthrough) and the key-mapping logic in emu, clocked by clk_sys.

Parameters:
- FILT_LEN, 8: consecutive clk_sys samples at a new level before the filtered PS/2 clock changes state.
- TIMEOUT, 50000: clk_sys cycles without a filtered falling edge, mid-frame, before the frame is aborted.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ps2_clk_i  in  1  raw PS/2 clock, asynchronous, idle high.
- ps2_dat_i  in  1  raw PS/2 data, asynchronous, idle high.
- ps2_key  out  11  key event word: [10] toggles once per event, [9]=1 for make, [8]=E0 prefix seen, [7:0] code.
- frame_err  out  1  one-cycle pulse when a frame is rejected by parity, stop bit or timeout.

Behaviour:
- One clock domain; reset is synchronous and active-high. RESET must be held at least 1 cycle.
- Reset values: ps2_key=0, frame_err=0, state IDLE, bit count 0, ext=0, rel=0, filtered clock=1, timeout counter 0.
- Input path: both lines pass through a 2-FF synchroniser.
  - Filtered clock flips only after FILT_LEN consecutive synced samples differ from its current value.
  - A glitch shorter than FILT_LEN cycles has no effect.
  - fall = 1-cycle pulse on each filtered 1->0 transition.
  - Data is taken from the synced data line in the cycle fall is high.
- State IDLE:
  - On fall with data=0 (start bit): go to SHIFT, bit count 0, timeout counter cleared.
  - On fall with data=1: ignored, stay in IDLE, no error.
- State SHIFT:
  - On each fall, capture the bit. Bits 1-8 are data, LSB first; bit 9 is parity; bit 10 is stop.
  - After bit 10: go to CHECK.
- State CHECK (1 cycle): the frame is valid when the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop=1.
  - Valid, byte 0xE0: set ext, no output.
  - Valid, byte 0xF0: set rel, no output.
  - Valid, any other byte (including 0xE1): ps2_key <= {~ps2_key[10], ~rel, ext, byte}, then clear ext and rel.
  - Invalid: frame_err=1 for this cycle, clear ext and rel, ps2_key unchanged.
  - Always return to IDLE.
- Latency: ps2_key is updated 2 cycles after the fall pulse that samples the stop bit (fall cycle N, CHECK in N+1, register visible in N+2).
- Output coherence: bits [9:0] and bit [10] change in the same cycle. A consumer may sample [9:0] on any change of [10].
- Timeout:
  - In SHIFT, the counter increments every cycle without fall and clears on fall.
  - When it reaches TIMEOUT: frame_err pulse, return to IDLE, clear bit count, ext and rel.
  - The counter saturates and is inactive in IDLE.
- Reset mid-frame: everything returns to reset values immediately; a partial frame is discarded without an error pulse.
- ps2_key holds its value indefinitely between events. No handshake; events closer together than one frame cannot occur.

Decomposition:
- Package ps2_pkg:
  - constants PS2_PFX_EXT=8'hE0, PS2_PFX_REL=8'hF0, PS2_FRAME_BITS=11;
  - state enum {IDLE, SHIFT, CHECK}.
- Sub-module ps2_line_filter: 2-FF synchronisers, FILT_LEN filter on the clock line, outputs filtered clock, synced data and the fall pulse.
- Top: FSM, shift register, prefix flags, timeout counter.

Test Plan:
- Bench stimulus: a PS/2 device model with a 40-cycle half-period, FILT_LEN=8, TIMEOUT=2000.
- Reset, then frame 0x1C with parity 0 -> ps2_key=11'h61C, frame_err stays 0, update exactly 2 cycles after the stop-bit fall.
- From 11'h61C, send F0 then 1C -> no change after F0; after 1C ps2_key=11'h01C.
- From 11'h01C, send E0 then 75 (parity 0) -> ps2_key=11'h775. Then E0 F0 75 -> 11'h175.
- Send 0x29 with parity 1 -> frame_err high for exactly 1 cycle, ps2_key unchanged. Then 0x29 with parity 0 -> [10] toggles, [9:0]=10'h229.
- Send start plus 4 data bits, then hold the clock high 2001 cycles -> frame_err pulse, state IDLE. A following 0x16 frame decodes correctly ([9:0]=10'h216).
- Clock low pulses of 7 cycles between frames -> no bit counted, no error.
- Assert RESET after bit 5 of a frame -> ps2_key=0, no frame_err. A following 0x1C frame gives 11'h61C.
